// File: rtl/axi_stream_fifo_v2.sv
// axi_stream_fifo_v2: single-clock AXI-Stream FIFO on a circular buffer.
// Each entry holds {tlast, tuser, data}. The read path is first-word-fall-through
// with one cycle of latency. Level flags and an optional store-and-forward
// (packet) mode are provided.
module axi_stream_fifo_v2 #(
  parameter int DATA_BYTES  = 2,
  parameter int DEPTH       = 16,
  parameter int USER_W      = 1,
  parameter int AF_LEVEL    = DEPTH - 2,
  parameter int AE_LEVEL    = 2,
  parameter int PACKET_MODE = 0,
  localparam int DATA_W     = 8 * DATA_BYTES,
  localparam int LVL_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] iAXI_data,
  input  logic              iAXI_valid,
  output logic              iAXI_ready,
  input  logic [USER_W-1:0] iAXI_tuser,
  input  logic              iAXI_tlast,
  output logic [DATA_W-1:0] oAXI_data,
  output logic              oAXI_valid,
  input  logic              oAXI_ready,
  output logic [USER_W-1:0] oAXI_tuser,
  output logic              oAXI_tlast,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int ENTRY_W = 1 + USER_W + DATA_W;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [LVL_W-1:0]   r_pkt_cnt;
  logic               r_init;
  logic               r_release;

  logic [ENTRY_W-1:0] w_head;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic               w_push_last;
  logic               w_pop_last;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [LVL_W-1:0]   w_pkt_cnt_nxt;

  // Depth need not be a power of two, so pointers wrap on an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flags come straight from the registered level.
  assign level        = r_level;
  assign full         = (r_level == LVL_W'(DEPTH));
  assign empty        = (r_level == '0);
  assign almost_full  = (r_level >= LVL_W'(AF_LEVEL));
  assign almost_empty = (r_level <= LVL_W'(AE_LEVEL));

  // Ready only reflects space; a pop in the same cycle never frees a slot early.
  assign iAXI_ready = r_init && !full;

  // In packet mode the head is released once a whole packet is stored, or when
  // the buffer is full (a packet longer than DEPTH would otherwise deadlock).
  // r_release keeps such an oversized packet flowing once it has started.
  assign w_head      = r_mem[r_rd_ptr];
  assign w_out_valid = (PACKET_MODE != 0)
                     ? (!empty && ((r_pkt_cnt != '0) || full || r_release))
                     : !empty;

  assign oAXI_valid = w_out_valid;
  assign oAXI_data  = w_out_valid ? w_head[DATA_W-1:0]        : '0;
  assign oAXI_tuser = w_out_valid ? w_head[DATA_W +: USER_W]  : '0;
  assign oAXI_tlast = w_out_valid ? w_head[ENTRY_W-1]         : 1'b0;

  assign w_push      = iAXI_valid && iAXI_ready;
  assign w_pop       = w_out_valid && oAXI_ready;
  assign w_push_last = w_push && iAXI_tlast;
  assign w_pop_last  = w_pop && w_head[ENTRY_W-1];

  // Next level and next complete-packet count from this cycle's handshakes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_level_nxt   = r_level;
    w_pkt_cnt_nxt = r_pkt_cnt;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
    if (w_push_last && !w_pop_last) begin
      w_pkt_cnt_nxt = r_pkt_cnt + LVL_W'(1);
    end else if (!w_push_last && w_pop_last) begin
      w_pkt_cnt_nxt = r_pkt_cnt - LVL_W'(1);
    end
  end

  // Storage write; flush discards a beat offered in the same cycle.
  // NOTE: the storage array has no reset; pointers and level alone define valid content.
  always_ff @(posedge aclk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= {iAXI_tlast, iAXI_tuser, iAXI_data};
    end
  end

  // Control state: init flag, pointers, level, packet count and release latch.
  always_ff @(posedge aclk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_init    <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_pkt_cnt <= '0;
      r_release <= 1'b0;
    end else begin
      r_init <= 1'b1;
      if (flush) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_level   <= '0;
        r_pkt_cnt <= '0;
        r_release <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_level   <= w_level_nxt;
        r_pkt_cnt <= w_pkt_cnt_nxt;
        if ((w_level_nxt == '0) || w_pop_last) begin
          r_release <= 1'b0;
        end else if (full) begin
          r_release <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_fifo_v2.sv
// Directed bench for axi_stream_fifo_v2: a DEPTH=5 cut-through instance and a
// DEPTH=8 packet-mode instance share clock and reset.
module tb_axi_stream_fifo_v2;

  logic        aclk;
  logic        rst;

  logic        c_flush, c_ivalid, c_iready, c_ilast, c_ovalid, c_oready, c_olast;
  logic [15:0] c_idata, c_odata;
  logic [0:0]  c_iuser, c_ouser;
  logic [2:0]  c_level;
  logic        c_full, c_empty, c_af, c_ae;

  logic        p_flush, p_ivalid, p_iready, p_ilast, p_ovalid, p_oready, p_olast;
  logic [15:0] p_idata, p_odata;
  logic [0:0]  p_iuser, p_ouser;
  logic [3:0]  p_level;
  logic        p_full, p_empty, p_af, p_ae;

  int n_pass  = 0;
  int n_total = 0;

  axi_stream_fifo_v2 #(.DATA_BYTES(2), .DEPTH(5), .USER_W(1), .PACKET_MODE(0)) u_cut (
    .aclk(aclk), .rst(rst), .flush(c_flush),
    .iAXI_data(c_idata), .iAXI_valid(c_ivalid), .iAXI_ready(c_iready),
    .iAXI_tuser(c_iuser), .iAXI_tlast(c_ilast),
    .oAXI_data(c_odata), .oAXI_valid(c_ovalid), .oAXI_ready(c_oready),
    .oAXI_tuser(c_ouser), .oAXI_tlast(c_olast),
    .level(c_level), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae)
  );

  axi_stream_fifo_v2 #(.DATA_BYTES(2), .DEPTH(8), .USER_W(1), .PACKET_MODE(1)) u_pkt (
    .aclk(aclk), .rst(rst), .flush(p_flush),
    .iAXI_data(p_idata), .iAXI_valid(p_ivalid), .iAXI_ready(p_iready),
    .iAXI_tuser(p_iuser), .iAXI_tlast(p_ilast),
    .oAXI_data(p_odata), .oAXI_valid(p_ovalid), .oAXI_ready(p_oready),
    .oAXI_tuser(p_ouser), .oAXI_tlast(p_olast),
    .level(p_level), .full(p_full), .empty(p_empty),
    .almost_full(p_af), .almost_empty(p_ae)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge and sample 1ns later; level must never leave [0, DEPTH].
  task automatic tick();
    @(posedge aclk);
    #1;
    n_total++;
    if (c_level > 3'd5 || p_level > 4'd8)
      $display("FAIL level_bound: cut=%0d pkt=%0d limits 5/8", c_level, p_level);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_total++;
    if ({c_iready, c_ovalid, c_empty, c_full, c_ae, c_af, c_level, c_odata} !== {6'b001010, 3'd0, 16'h0})
      $display("FAIL reset_cut: got %b/%0d/%h", {c_iready, c_ovalid, c_empty, c_full, c_ae, c_af}, c_level, c_odata);
    else n_pass++;
    n_total++;
    if ({p_iready, p_ovalid, p_empty, p_full, p_ae, p_af, p_level, p_odata} !== {6'b001010, 4'd0, 16'h0})
      $display("FAIL reset_pkt: got %b/%0d/%h", {p_iready, p_ovalid, p_empty, p_full, p_ae, p_af}, p_level, p_odata);
    else n_pass++;
    tick();
    tick();
    rst = 1'b1;
    n_total++;
    if ({c_iready, p_iready} !== 2'b00) $display("FAIL init_ready_low: got %b want 00", {c_iready, p_iready});
    else n_pass++;
    tick();
    n_total++;
    if ({c_iready, p_iready} !== 2'b11) $display("FAIL init_ready_high: got %b want 11", {c_iready, p_iready});
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    c_oready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      n_total++;
      if (c_iready !== 1'b1) $display("FAIL fill_ready k=%0d: got %b want 1", k, c_iready);
      else n_pass++;
      c_ivalid = 1'b1; c_idata = 16'(k); c_iuser = 1'(k % 2); c_ilast = 1'b0;
      tick();
      n_total++;
      if ({c_level, c_af, c_ae} !== {3'(k), 1'(k >= 3), 1'(k <= 2)})
        $display("FAIL fill_flags k=%0d: got lvl=%0d af=%b ae=%b", k, c_level, c_af, c_ae);
      else n_pass++;
    end
    c_ivalid = 1'b0;
    n_total++;
    if ({c_full, c_iready, c_ovalid, c_odata} !== {3'b101, 16'h0001})
      $display("FAIL full_state: got full=%b rdy=%b vld=%b data=%h", c_full, c_iready, c_ovalid, c_odata);
    else n_pass++;
    c_oready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      n_total++;
      if ({c_ovalid, c_ouser, c_odata} !== {1'b1, 1'(k % 2), 16'(k)})
        $display("FAIL drain_order k=%0d: got vld=%b user=%b data=%h", k, c_ovalid, c_ouser, c_odata);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({c_empty, c_ovalid, c_full, c_level, c_odata} !== {3'b100, 3'd0, 16'h0})
      $display("FAIL drain_empty: got e=%b v=%b f=%b lvl=%0d data=%h", c_empty, c_ovalid, c_full, c_level, c_odata);
    else n_pass++;
    c_oready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    c_oready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d = 16'h0100 + 16'(k);
      c_ivalid = 1'b1; c_idata = d;
      n_total++;
      if (c_ovalid !== 1'b0) $display("FAIL no_bypass k=%0d: got vld=%b want 0", k, c_ovalid);
      else n_pass++;
      tick();
      c_ivalid = 1'b0;
      n_total++;
      if ({c_ovalid, c_level, c_odata} !== {1'b1, 3'd1, d})
        $display("FAIL wrap_out k=%0d: got vld=%b lvl=%0d data=%h want %h", k, c_ovalid, c_level, c_odata, d);
      else n_pass++;
      tick();
      n_total++;
      if ({c_empty, c_ovalid, c_level} !== {2'b10, 3'd0})
        $display("FAIL wrap_empty k=%0d: got e=%b v=%b lvl=%0d", k, c_empty, c_ovalid, c_level);
      else n_pass++;
    end
    c_oready = 1'b0;
  endtask

  task automatic test_simultaneous();
    c_oready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      c_ivalid = 1'b1; c_idata = 16'h0201 + 16'(j);
      tick();
    end
    c_oready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      c_ivalid = 1'b1; c_idata = 16'h0204 + 16'(j);
      n_total++;
      if (c_odata !== 16'h0201 + 16'(j)) $display("FAIL simul_order j=%0d: got %h want %h", j, c_odata, 16'h0201 + 16'(j));
      else n_pass++;
      tick();
      n_total++;
      if (c_level !== 3'd3) $display("FAIL simul_level j=%0d: got %0d want 3", j, c_level);
      else n_pass++;
    end
    c_oready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      c_ivalid = 1'b1; c_idata = 16'h0208 + 16'(j);
      tick();
    end
    c_oready = 1'b1; c_ivalid = 1'b1; c_idata = 16'h020A;
    n_total++;
    if ({c_full, c_iready, c_odata} !== {2'b10, 16'h0205})
      $display("FAIL full_pop_ready: got full=%b rdy=%b data=%h", c_full, c_iready, c_odata);
    else n_pass++;
    tick();
    c_ivalid = 1'b0; c_oready = 1'b0;
    n_total++;
    if ({c_level, c_iready} !== {3'd4, 1'b1}) $display("FAIL after_full_pop: got lvl=%0d rdy=%b want 4/1", c_level, c_iready);
    else n_pass++;
    c_oready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_total++;
      if ({c_ovalid, c_odata} !== {1'b1, 16'h0206 + 16'(j)})
        $display("FAIL full_drain j=%0d: got vld=%b data=%h", j, c_ovalid, c_odata);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({c_empty, c_ovalid} !== 2'b10) $display("FAIL rejected_beat_absent: got e=%b v=%b want 1/0", c_empty, c_ovalid);
    else n_pass++;
    c_oready = 1'b0;
  endtask

  task automatic test_flush();
    c_oready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      c_ivalid = 1'b1; c_idata = 16'h0301 + 16'(j);
      tick();
    end
    n_total++;
    if (c_level !== 3'd4) $display("FAIL pre_flush_level: got %0d want 4", c_level);
    else n_pass++;
    c_flush = 1'b1; c_ivalid = 1'b1; c_idata = 16'h0399;
    tick();
    c_flush = 1'b0; c_ivalid = 1'b0;
    n_total++;
    if ({c_level, c_empty, c_ovalid, c_iready, c_odata} !== {3'd0, 3'b101, 16'h0})
      $display("FAIL flush_state: got lvl=%0d e=%b v=%b rdy=%b data=%h", c_level, c_empty, c_ovalid, c_iready, c_odata);
    else n_pass++;
    c_ivalid = 1'b1; c_idata = 16'hBEEF;
    tick();
    c_ivalid = 1'b0;
    n_total++;
    if ({c_ovalid, c_level, c_odata} !== {1'b1, 3'd1, 16'hBEEF})
      $display("FAIL post_flush_beat: got v=%b lvl=%0d data=%h", c_ovalid, c_level, c_odata);
    else n_pass++;
    c_oready = 1'b1;
    tick();
    n_total++;
    if ({c_empty, c_ovalid} !== 2'b10) $display("FAIL post_flush_alone: got e=%b v=%b", c_empty, c_ovalid);
    else n_pass++;
    c_oready = 1'b0;
  endtask

  task automatic test_packet();
    int n_in;
    int n_out;
    p_oready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      p_ivalid = 1'b1; p_idata = 16'h0401 + 16'(j); p_ilast = 1'b0;
      tick();
      n_total++;
      if ({p_ovalid, p_level} !== {1'b0, 4'(j + 1)}) $display("FAIL pkt_hold j=%0d: got v=%b lvl=%0d", j, p_ovalid, p_level);
      else n_pass++;
    end
    p_idata = 16'h0404; p_ilast = 1'b1;
    tick();
    p_ivalid = 1'b0; p_ilast = 1'b0;
    n_total++;
    if ({p_ovalid, p_level, p_odata, u_pkt.r_pkt_cnt} !== {1'b1, 4'd4, 16'h0401, 4'd1})
      $display("FAIL pkt_release: got v=%b lvl=%0d data=%h cnt=%0d", p_ovalid, p_level, p_odata, u_pkt.r_pkt_cnt);
    else n_pass++;
    for (int j = 0; j < 4; j++) begin
      n_total++;
      if ({p_ovalid, p_olast, p_odata} !== {1'b1, 1'(j == 3), 16'h0401 + 16'(j)})
        $display("FAIL pkt_pop j=%0d: got v=%b last=%b data=%h", j, p_ovalid, p_olast, p_odata);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({p_ovalid, p_empty, p_level, u_pkt.r_pkt_cnt} !== {2'b01, 4'd0, 4'd0})
      $display("FAIL pkt_done: got v=%b e=%b lvl=%0d cnt=%0d", p_ovalid, p_empty, p_level, u_pkt.r_pkt_cnt);
    else n_pass++;

    // Oversized packet: 10 beats into 8 entries.
    for (int j = 0; j < 8; j++) begin
      p_ivalid = 1'b1; p_idata = 16'h0501 + 16'(j); p_ilast = 1'b0;
      tick();
      if (j < 7) begin
        n_total++;
        if (p_ovalid !== 1'b0) $display("FAIL long_hold j=%0d: got v=%b want 0", j, p_ovalid);
        else n_pass++;
      end
    end
    p_ivalid = 1'b0;
    n_total++;
    if ({p_full, p_iready, p_ovalid, p_odata} !== {3'b101, 16'h0501})
      $display("FAIL long_full_release: got f=%b rdy=%b v=%b data=%h", p_full, p_iready, p_ovalid, p_odata);
    else n_pass++;
    n_in = 8;
    n_out = 0;
    for (int cyc = 0; cyc < 40 && n_out < 10; cyc++) begin
      if (n_in < 10) begin
        p_ivalid = 1'b1; p_idata = 16'h0501 + 16'(n_in); p_ilast = (n_in == 9);
      end else begin
        p_ivalid = 1'b0; p_ilast = 1'b0;
      end
      n_total++;
      if ({p_ovalid, p_olast, p_odata} !== {1'b1, 1'(n_out == 9), 16'h0501 + 16'(n_out)})
        $display("FAIL long_stream n=%0d: got v=%b last=%b data=%h", n_out, p_ovalid, p_olast, p_odata);
      else n_pass++;
      if (p_ovalid && p_oready) n_out++;
      if (p_ivalid && p_iready) n_in++;
      tick();
    end
    p_ivalid = 1'b0; p_ilast = 1'b0;
    n_total++;
    if (n_out !== 10) $display("FAIL long_timeout: delivered %0d beats want 10", n_out);
    else n_pass++;
    n_total++;
    if ({p_ovalid, p_empty, u_pkt.r_pkt_cnt} !== {2'b01, 4'd0})
      $display("FAIL long_done: got v=%b e=%b cnt=%0d", p_ovalid, p_empty, u_pkt.r_pkt_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    c_oready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      c_ivalid = 1'b1; c_idata = 16'h0601 + 16'(j);
      tick();
    end
    n_total++;
    if ({c_level, c_ovalid} !== {3'd3, 1'b1}) $display("FAIL pre_reset: got lvl=%0d v=%b", c_level, c_ovalid);
    else n_pass++;
    c_idata = 16'h0604;
    rst = 1'b0;
    #1;
    n_total++;
    if ({c_iready, c_ovalid, c_empty, c_full, c_ae, c_af, c_level, c_odata, c_olast} !== {6'b001010, 3'd0, 16'h0, 1'b0})
      $display("FAIL reset_immediate: got %b lvl=%0d data=%h", {c_iready, c_ovalid, c_empty, c_full, c_ae, c_af}, c_level, c_odata);
    else n_pass++;
    tick();
    c_ivalid = 1'b0;
    rst = 1'b1;
    n_total++;
    if ({c_iready, c_empty} !== 2'b01) $display("FAIL reset_release: got rdy=%b e=%b want 0/1", c_iready, c_empty);
    else n_pass++;
    tick();
    n_total++;
    if ({c_iready, c_empty, c_ovalid, c_level} !== {3'b110, 3'd0})
      $display("FAIL reset_after: got rdy=%b e=%b v=%b lvl=%0d", c_iready, c_empty, c_ovalid, c_level);
    else n_pass++;
  endtask

  initial begin
    c_flush = 1'b0; c_ivalid = 1'b0; c_idata = '0; c_iuser = '0; c_ilast = 1'b0; c_oready = 1'b0;
    p_flush = 1'b0; p_ivalid = 1'b0; p_idata = '0; p_iuser = '0; p_ilast = 1'b0; p_oready = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_packet();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_stream_fifo_v2.md
Name: axi_stream_fifo_v2

Overview:
- Parametrised single-clock AXI-Stream FIFO; next generation of the AXI_FIFO stage sitting between an upstream stream producer and a downstream consumer.
- Features:
  - Strict first-in-first-out order on a circular buffer.
  - Arbitrary byte width and depth.
  - tuser/tlast sideband carried with each beat.
  - Simultaneous push and pop in one cycle.
  - Fill-level and threshold flags.
  - Synchronous flush.
  - Optional packet (store-and-forward) mode.

Parameters:
- DATA_BYTES, 2, data beat width in bytes (data bus = 8*DATA_BYTES bits).
- DEPTH, 16, number of entries, ≥2, not necessarily a power of two.
- USER_W, 1, tuser width.
- AF_LEVEL, DEPTH-2, almost_full asserts when level ≥ AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when level ≤ AE_LEVEL.
- PACKET_MODE, 0, 0 = cut-through; 1 = output only complete packets.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear, active-high.
- iAXI_data  in  8*DATA_BYTES  input beat data.
- iAXI_valid  in  1  input beat valid.
- iAXI_ready  out  1  FIFO can accept a beat.
- iAXI_tuser  in  USER_W  input sideband.
- iAXI_tlast  in  1  last beat of packet.
- oAXI_data  out  8*DATA_BYTES  output beat data.
- oAXI_valid  out  1  output beat valid.
- oAXI_ready  in  1  downstream accepts.
- oAXI_tuser  out  USER_W  output sideband.
- oAXI_tlast  out  1  output last beat.
- level  out  $clog2(DEPTH+1)  current number of stored beats.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_LEVEL.
- almost_empty  out  1  level ≤ AE_LEVEL.

Behaviour:

Reset and initialisation:
- rst low: pointers, level and pkt_cnt = 0; init flag cleared.
- Outputs during reset: iAXI_ready=0, oAXI_valid=0, oAXI_data/tuser/tlast=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0.
- Storage array is not reset.
- Init flag sets on first aclk edge after rst deasserts; iAXI_ready is low until then.
- Reset mid-transfer discards all content immediately; no partial beat survives.

Handshakes:
- Push = iAXI_valid && iAXI_ready.
- Pop = oAXI_valid && oAXI_ready.
- iAXI_ready = init && !full. It does not depend on oAXI_ready; no push is accepted when full, even if a pop occurs that cycle.

Storage and latency:
- Write pointer and read pointer wrap from DEPTH-1 to 0. Explicit wrap compare is required, not power-of-two masking.
- Each entry stores {tlast, tuser, data}.
- First-word-fall-through: a beat pushed on edge N is presented with oAXI_valid=1 after edge N (one-cycle latency). There is no same-cycle bypass into an empty FIFO.
- oAXI_data/tuser/tlast are taken from the read-pointer entry and forced to 0 whenever oAXI_valid=0.
- While oAXI_valid=1 && oAXI_ready=0, outputs hold stable.

Level update:
- Push only: +1.
- Pop only: -1.
- Push and pop together: unchanged, both pointers advance.
- All flags derive combinationally from the registered level.

Flush:
- Pointers, level and pkt_cnt return to 0 on the edge where flush=1.
- flush overrides any push/pop in the same cycle; those beats are lost.
- iAXI_ready stays as computed (full drops).

Packet mode (PACKET_MODE=1):
- pkt_cnt tracks complete packets stored, width $clog2(DEPTH+1).
- pkt_cnt +1 on a push with tlast=1; -1 on a pop with tlast=1; unchanged if both occur.
- oAXI_valid = !empty && (pkt_cnt>0 || full).
- The `full` term releases packets longer than DEPTH in cut-through fashion to avoid deadlock.
- Once oAXI_valid rises under the `full` override, it stays asserted until the beat with tlast pops or the FIFO empties. A release-latch register implements this hold.

Cut-through mode (PACKET_MODE=0):
- oAXI_valid = !empty.
- tlast is passed through and has no effect on flow control.

Boundary conditions:
- Pop of the last stored beat with no push: empty=1 after that edge, oAXI_valid=0.
- Push into DEPTH-1 with no pop: full=1, iAXI_ready=0 after that edge.
- No overflow or underflow is possible by construction. The bench asserts level never exceeds DEPTH and never wraps below 0.

Test Plan:
1. DEPTH=5, PACKET_MODE=0: push 0x0001..0x0005 with oAXI_ready=0 → full=1, iAXI_ready=0, level=5, almost_full=1; then oAXI_ready=1 → pops 0x0001..0x0005 in order, empty=1 after 5th.
2. Wrap-around: DEPTH=5, 12 beats streamed with oAXI_ready held 1 → output sequence equals input, each beat appears one cycle after its push, level oscillates 0/1, pointers wrap twice without error.
3. Simultaneous push/pop at level=3 (DEPTH=5) for 4 cycles → level stays 3, order preserved; at full with oAXI_ready=1 → iAXI_ready still 0 that cycle, 1 next.
4. PACKET_MODE=1, DEPTH=8: push 3 beats without tlast → oAXI_valid=0; push 4th with tlast=1 → oAXI_valid=1 next cycle, 4 beats pop, tlast=1 on 4th, pkt_cnt=0. Then a 10-beat packet → full forces release, all 10 beats delivered in order.
5. Flush at level=4 with concurrent push → next cycle level=0, empty=1, oAXI_valid=0, pushed beat lost; following push 0xBEEF appears alone.
6. rst pulled low mid-stream at level=3 → outputs immediately at reset values; after release iAXI_ready=0 for one edge then 1, FIFO empty.
